// File: rtl/onehot_count_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_count_accumulator
//  Description : Windowed accumulator for the one-hot outputs of the 4-input
//                population-count stage. It decodes each accepted sample
//                (v=0, w=1, x=2, y=3, z=4) and sums the values with
//                saturation. The sum is published after WINDOW samples with a
//                one-cycle valid pulse. Any accepted sample that is not
//                strictly one-hot sets a sticky error flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WINDOW      samples per window, 1..255
//    SUM_W       width of sum; 2**SUM_W-1 >= 4*WINDOW for a lossless total
//  Ports
//    clk         rising-edge clock
//    reset       synchronous active-high reset, priority over start/ena
//    ena         sample-accept enable (honoured in ACCUM only)
//    start       open a new window (honoured in IDLE only)
//    v,w,x,y,z   one-hot count inputs representing 0..4
//    sum         last completed window total (registered)
//    sum_valid   one-cycle pulse in the cycle after sum is updated
//    busy        high while a window is running or being published
//    onehot_err  sticky flag: a non-one-hot sample was accepted
//    sample_cnt  samples accepted in the current/last window
// ============================================================================
module onehot_count_accumulator #(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             start,
  input  logic             v,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             onehot_err,
  output logic [7:0]       sample_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0]       WIN_C   = 8'(WINDOW);
  localparam logic [SUM_W-1:0] SAT_MAX = '1;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q,   acc_d;
  logic [SUM_W-1:0] sum_q,   sum_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic [4:0]       w_pat;
  logic [2:0]       w_val;
  logic             w_onehot;
  logic [SUM_W:0]   w_acc_wide;
  logic [SUM_W-1:0] w_acc_next;
  logic [7:0]       w_cnt_inc;

  assign w_pat = {z, y, x, w, v};

  // Decode: only the five strictly one-hot patterns carry a value; every
  // other pattern (none or several bits set) counts as 0 and is flagged.
  always_comb begin
    w_val    = 3'd0;
    w_onehot = 1'b1;
    unique case (w_pat)
      5'b00001: w_val = 3'd0;
      5'b00010: w_val = 3'd1;
      5'b00100: w_val = 3'd2;
      5'b01000: w_val = 3'd3;
      5'b10000: w_val = 3'd4;
      default: begin
        w_val    = 3'd0;
        w_onehot = 1'b0;
      end
    endcase
  end

  // One extra bit catches the carry out; on carry the total clamps to all-ones.
  // Any legal SUM_W is at least 3, so the value fits the zero extension.
  assign w_acc_wide = {1'b0, acc_q} + {{(SUM_W - 2){1'b0}}, w_val};
  assign w_acc_next = w_acc_wide[SUM_W] ? SAT_MAX : w_acc_wide[SUM_W-1:0];
  assign w_cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        // sum deliberately survives a new start; only the window state clears.
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (ena) begin
          acc_d = w_acc_next;
          cnt_d = w_cnt_inc;
          if (!w_onehot) begin
            err_d = 1'b1;
          end
          // The closing sample is folded in before publishing.
          if (w_cnt_inc == WIN_C) begin
            sum_d   = w_acc_next;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Every output comes straight from registers or from decoded state.
  assign sum        = sum_q;
  assign sum_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign onehot_err = err_q;
  assign sample_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_count_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_count_accumulator
//  Description : Self-checking bench. Two instances (SUM_W=8 and SUM_W=3,
//                both WINDOW=4) share one stimulus stream; a window-level
//                reference model predicts every output each cycle, and
//                directed scenarios pin literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onehot_count_accumulator;

  localparam int WIN = 4;

  logic       clk = 1'b0;
  logic       reset, ena, start;
  logic [4:0] pat;

  logic [7:0] sum8;
  logic [2:0] sum3;
  logic       valid8, busy8, err8, valid3, busy3, err3;
  logic [7:0] cnt8, cnt3;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  always #5 clk = ~clk;

  onehot_count_accumulator #(.WINDOW(WIN), .SUM_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .ena(ena), .start(start),
    .v(pat[0]), .w(pat[1]), .x(pat[2]), .y(pat[3]), .z(pat[4]),
    .sum(sum8), .sum_valid(valid8), .busy(busy8),
    .onehot_err(err8), .sample_cnt(cnt8)
  );

  onehot_count_accumulator #(.WINDOW(WIN), .SUM_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .ena(ena), .start(start),
    .v(pat[0]), .w(pat[1]), .x(pat[2]), .y(pat[3]), .z(pat[4]),
    .sum(sum3), .sum_valid(valid3), .busy(busy3),
    .onehot_err(err3), .sample_cnt(cnt3)
  );

  // ---------------- reference model (window-level view) ----------------
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  int m_total  = 0;
  int m_cnt    = 0;
  int m_sum8   = 0;
  int m_sum3   = 0;

  function automatic int sample_value(input logic [4:0] p);
    int val = 0;
    if ($countones(p) == 1)
      for (int i = 0; i < 5; i++)
        if (p[i]) val = i;
    return val;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_total = 0; m_cnt = 0; m_sum8 = 0; m_sum3 = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (ena) begin
        m_total += sample_value(pat);
        if ($countones(pat) != 1) m_err = 1'b1;
        m_cnt++;
        if (m_cnt == WIN) begin
          m_sum8   = (m_total > 255) ? 255 : m_total;
          m_sum3   = (m_total > 7)   ? 7   : m_total;
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start) begin
      m_active = 1'b1; m_total = 0; m_cnt = 0; m_err = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sum8",        32'(sum8),   32'(m_sum8));
      check("sum_valid8",  32'(valid8), 32'(m_done));
      check("busy8",       32'(busy8),  32'(m_active | m_done));
      check("onehot_err8", 32'(err8),   32'(m_err));
      check("sample_cnt8", 32'(cnt8),   32'(m_cnt));
      check("sum3",        32'(sum3),   32'(m_sum3));
      check("sum_valid3",  32'(valid3), 32'(m_done));
      check("busy3",       32'(busy3),  32'(m_active | m_done));
      check("onehot_err3", 32'(err3),   32'(m_err));
      check("sample_cnt3", 32'(cnt3),   32'(m_cnt));
    end
  end

  // One clock cycle: apply inputs, let the edge take them, settle 1 time unit.
  task automatic cyc(input bit r, input bit s, input bit e, input logic [4:0] p);
    reset = r; start = s; ena = e; pat = p;
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] PV = 5'b00001;
  localparam logic [4:0] PW = 5'b00010;
  localparam logic [4:0] PX = 5'b00100;
  localparam logic [4:0] PY = 5'b01000;
  localparam logic [4:0] PZ = 5'b10000;

  logic [4:0] seq [4];
  logic [4:0] rp;

  initial begin
    // ---- reset with random inputs and start held high ----
    cyc(1'b1, 1'b1, 1'b1, 5'($urandom));
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 5'($urandom));
    check("rst_sum",   32'(sum8),   32'd0);
    check("rst_valid", 32'(valid8), 32'd0);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_err",   32'(err8),   32'd0);
    check("rst_cnt",   32'(cnt8),   32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    check("rst_start_ignored", 32'(busy8), 32'd0);

    // ---- basic window: w x y z -> 10 ----
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    check("basic_busy_after_start", 32'(busy8), 32'd1);
    seq[0] = PW; seq[1] = PX; seq[2] = PY; seq[3] = PZ;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, seq[i]);
    check("basic_valid", 32'(valid8), 32'd1);
    check("basic_sum",   32'(sum8),   32'd10);
    check("basic_err",   32'(err8),   32'd0);
    check("basic_cnt",   32'(cnt8),   32'd4);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    check("basic_valid_drop", 32'(valid8), 32'd0);
    check("basic_busy_drop",  32'(busy8),  32'd0);

    // ---- stall: ena low on alternate cycles with random junk ----
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, seq[i]);
      if (i < 3) begin
        cyc(1'b0, 1'b0, 1'b0, 5'($urandom));
        check("stall_no_valid", 32'(valid8), 32'd0);
      end
    end
    check("stall_valid", 32'(valid8), 32'd1);
    check("stall_sum",   32'(sum8),   32'd10);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // ---- illegal pattern: {v&w}, z, z, z -> 12 with error ----
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    seq[0] = PV | PW; seq[1] = PZ; seq[2] = PZ; seq[3] = PZ;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, seq[i]);
    check("illegal_sum", 32'(sum8), 32'd12);
    check("illegal_err", 32'(err8), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    check("illegal_err_held", 32'(err8), 32'd1);
    // all-zero sample: adds 0, flags error; start clears the old flag first
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    check("start_clears_err", 32'(err8), 32'd0);
    seq[0] = 5'd0; seq[1] = PW; seq[2] = PW; seq[3] = PW;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, seq[i]);
    check("zero_sum", 32'(sum8), 32'd3);
    check("zero_err", 32'(err8), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // ---- ignored starts; z x4 -> 16, saturates to 7 at SUM_W=3 ----
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, PZ);
    check("zz_sum8", 32'(sum8), 32'd16);
    check("zz_sum3_sat", 32'(sum3), 32'd7);
    cyc(1'b0, 1'b1, 1'b1, PZ);
    check("done_start_ignored", 32'(busy8), 32'd0);
    check("done_cnt_held",      32'(cnt8),  32'd4);
    // mid-window reset
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, PZ);
    cyc(1'b0, 1'b0, 1'b1, PZ);
    cyc(1'b1, 1'b1, 1'b1, PZ);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_sum",  32'(sum8),  32'd0);
    check("midrst_cnt",  32'(cnt8),  32'd0);

    // ---- back-to-back windows ----
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, PW);
    check("b2b_first_sum", 32'(sum8), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);   // DONE cycle
    cyc(1'b0, 1'b1, 1'b0, 5'd0);   // first IDLE cycle: start taken
    check("b2b_restart_busy", 32'(busy8), 32'd1);
    seq[0] = PZ; seq[1] = PZ; seq[2] = PY; seq[3] = PV;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, seq[i]);
      check("b2b_old_sum_visible", 32'(sum8), 32'd4);
    end
    cyc(1'b0, 1'b0, 1'b1, seq[3]);
    check("b2b_second_sum", 32'(sum8), 32'd11);
    check("b2b_second_sum3", 32'(sum3), 32'd7);

    // ---- randomized traffic ----
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(9) < 7) rp = 5'b00001 << $urandom_range(4);
      else                       rp = 5'($urandom);
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0),
          ($urandom_range(3) != 0), rp);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
